froc_bus_monitor: RTL

- Parametrised capture and check block on the FRoC signal bus, between the DUT-side signal bus and the test controller.
- Registers FRoC state, intermediate LUT outputs and sink outputs each cycle. Compares the sinks against controller-supplied expected values.
- Logs every mismatching cycle into an on-chip FIFO, which the controller drains over a valid/ready port. Keeps saturating per-sink error counters.

---
 rtl/froc_bus_monitor.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/froc_bus_monitor.sv
// FRoC bus capture/check block: registers the signal bus, logs mismatching sink cycles into a FIFO,
// keeps saturating per-sink error counters. Define FROC_MON_INTERMEDIATE_CAPTURE_EN to log intermediates.
module froc_bus_monitor #(
  parameter int STATE_LENGTH      = 8,
  parameter int NUM_INTERMEDIATES = 16,
  parameter int NUM_SINKS         = 8,
  parameter int DEPTH             = 16,
  parameter int CNT_W             = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arm,
  input  logic                          stop,
  input  logic [STATE_LENGTH-1:0]       bus_state,
  input  logic [NUM_INTERMEDIATES-1:0]  bus_intermediates,
  input  logic [NUM_SINKS-1:0]          bus_sinks,
  input  logic [NUM_SINKS-1:0]          exp_sinks,
  input  logic                          cmp_en,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [STATE_LENGTH-1:0]       rd_state,
  output logic [NUM_SINKS-1:0]          rd_mask,
`ifdef FROC_MON_INTERMEDIATE_CAPTURE_EN
  output logic [NUM_INTERMEDIATES-1:0]  rd_intermediates,
`endif
  input  logic [$clog2(NUM_SINKS)-1:0]  cnt_sel,
  output logic [CNT_W-1:0]              err_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          overflow,
  output logic                          busy,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
`ifdef FROC_MON_INTERMEDIATE_CAPTURE_EN
  localparam int EW = NUM_INTERMEDIATES + STATE_LENGTH + NUM_SINKS;
`else
  localparam int EW = STATE_LENGTH + NUM_SINKS;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                  st_q, st_d;
  logic [STATE_LENGTH-1:0] state_p1, prev_state_p1;
  logic [NUM_SINKS-1:0]    sinks_p1, exp_p1, mask_p1;
  logic                    vld_p1;
  logic                    trans_p1, mism_p1, cap_act, log_p1;
  logic                    push, pop, full, empty;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [EW-1:0]           mem [DEPTH];
  logic [EW-1:0]           entry_p1, head;
  logic [CNT_W-1:0]        cnt_q [NUM_SINKS];

  // Stage p1: bus sampled every cycle regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1      <= '0;
      prev_state_p1 <= '0;
      sinks_p1      <= '0;
      exp_p1        <= '0;
      vld_p1        <= 1'b0;
    end else begin
      state_p1      <= bus_state;
      prev_state_p1 <= state_p1;
      sinks_p1      <= bus_sinks;
      exp_p1        <= exp_sinks;
      vld_p1        <= cmp_en;
    end
  end

`ifdef FROC_MON_INTERMEDIATE_CAPTURE_EN
  logic [NUM_INTERMEDIATES-1:0] inter_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inter_p1 <= '0;
    else        inter_p1 <= bus_intermediates;
  end

  assign entry_p1 = {inter_p1, state_p1, mask_p1};
`else
  logic unused_inter;
  assign unused_inter = ^bus_intermediates;
  assign entry_p1     = {state_p1, mask_p1};
`endif

  assign mask_p1  = sinks_p1 ^ exp_p1;
  assign mism_p1  = vld_p1 && (sinks_p1 != exp_p1);
  assign trans_p1 = (state_p1 != prev_state_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // The ARMED->CAPTURE transition cycle already counts as capture; arm suppresses logging.
  always_comb begin
    st_d    = st_q;
    cap_act = 1'b0;
    case (st_q)
      IDLE:    st_d = st_q;
      ARMED: begin
        if (trans_p1) begin
          st_d    = CAPTURE;
          cap_act = 1'b1;
        end
      end
      CAPTURE: begin
        cap_act = 1'b1;
        if (stop) st_d = DONE;
      end
      DONE:    st_d = st_q;
      default: st_d = IDLE;
    endcase
    if (arm) begin
      st_d    = ARMED;
      cap_act = 1'b0;
    end
  end

  assign log_p1 = cap_act && mism_p1;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rd_valid && rd_ready;
  assign push  = log_p1 && (!full || pop);

  // Stage p2: FIFO, counters and drop tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (arm) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (log_p1 && !push) begin
      drop_cnt <= sat_inc(drop_cnt);
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SINKS; k++) cnt_q[k] <= '0;
    end else if (arm) begin
      for (int k = 0; k < NUM_SINKS; k++) cnt_q[k] <= '0;
    end else if (log_p1) begin
      for (int k = 0; k < NUM_SINKS; k++)
        if (mask_p1[k]) cnt_q[k] <= sat_inc(cnt_q[k]);
    end
  end

  // Empty FIFO reads as zero so stale memory never leaks out after reset or arm.
  assign rd_valid = !empty;
  assign head     = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign rd_mask  = head[NUM_SINKS-1:0];
  assign rd_state = head[NUM_SINKS +: STATE_LENGTH];
`ifdef FROC_MON_INTERMEDIATE_CAPTURE_EN
  assign rd_intermediates = head[NUM_SINKS+STATE_LENGTH +: NUM_INTERMEDIATES];
`endif

  always_comb begin
    err_cnt = '0;
    if (int'(cnt_sel) < NUM_SINKS) err_cnt = cnt_q[cnt_sel];
  end

  assign busy      = (st_q == ARMED) || (st_q == CAPTURE);
  assign fsm_state = st_q;

endmodule
